// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory responder and its SRAM back end.
package mem_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
  localparam int unsigned SRAM_AW_DEFAULT   = 18;
  localparam int unsigned CNT_W             = 4;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  typedef enum logic {OP_RD, OP_WR} op_t;

endpackage

// File: rtl/sram_controller.sv
// Serves one 32-bit MEM-stage read/write as two half-word accesses to an
// external asynchronous 16-bit SRAM, holding ready low while busy.
module sram_controller
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEFAULT,
  parameter int unsigned SRAM_AW       = SRAM_AW_DEFAULT,
  parameter int unsigned ACCESS_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int unsigned      WORD_W   = SRAM_AW - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  op_t                op_q, op_cur;
  logic [WORD_W-1:0]  word_q, word_cur, word_live;
  logic [31:0]        wdata_q, wdata_cur;
  logic               req;
  logic [31:0]        offset;
  logic               unused_offset;

  logic [31:0]        read_data_next;
  logic [SRAM_AW-1:0] sram_addr_next;
  logic [15:0]        dq_out_next;
  logic               dq_oe_next, we_n_next, oe_n_next;

  // Byte address to SRAM word index; out-of-range addresses wrap silently.
  assign req           = rd_en | wr_en;
  assign offset        = address - BASE_ADDR;
  assign word_live     = offset[WORD_W+1:2];
  assign unused_offset = ^{offset[31:WORD_W+2], offset[1:0]};

  assign ready = (state == IDLE) ? ~req : (state == DONE);

  always_comb begin
    state_next     = state;
    cnt_next       = cnt + CNT_W'(1);
    op_cur         = op_q;
    word_cur       = word_q;
    wdata_cur      = wdata_q;
    read_data_next = read_data;
    sram_addr_next = sram_addr;
    dq_out_next    = sram_dq_out;
    dq_oe_next     = 1'b0;
    we_n_next      = 1'b1;
    oe_n_next      = 1'b1;

    case (state)
      IDLE: begin
        cnt_next  = '0;
        op_cur    = wr_en ? OP_WR : OP_RD;
        word_cur  = word_live;
        wdata_cur = write_data;
        if (req) state_next = LOW;
      end
      LOW: begin
        if (cnt == LAST_CNT) begin
          state_next = HIGH;
          cnt_next   = '0;
          if (op_q == OP_RD) read_data_next[15:0] = sram_dq_in;
        end
      end
      HIGH: begin
        if (cnt == LAST_CNT) begin
          state_next = DONE;
          cnt_next   = '0;
          if (op_q == OP_RD) read_data_next[31:16] = sram_dq_in;
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Pin values are registered, so they are derived from the upcoming phase/count.
    if (state_next == LOW || state_next == HIGH) begin
      sram_addr_next = {word_cur, (state_next == HIGH)};
      if (op_cur == OP_WR) begin
        dq_oe_next  = 1'b1;
        dq_out_next = (state_next == HIGH) ? wdata_cur[31:16] : wdata_cur[15:0];
        we_n_next   = (cnt_next == LAST_CNT);
      end else begin
        oe_n_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= OP_RD;
      word_q      <= '0;
      wdata_q     <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      read_data   <= read_data_next;
      sram_addr   <= sram_addr_next;
      sram_dq_out <= dq_out_next;
      sram_dq_oe  <= dq_oe_next;
      sram_we_n   <= we_n_next;
      sram_oe_n   <= oe_n_next;
      if (state == IDLE && req) begin
        op_q    <= op_cur;
        word_q  <= word_cur;
        wdata_q <= wdata_cur;
      end
    end
  end

endmodule
